// File: rtl/lane_serializer_if.sv
// Word handshake between the byte striper and one lane serializer.
interface lane_serializer_if;
  logic [31:0] lane_in;
  logic        valid_in;
  logic        ready_out;

  modport master (output lane_in, output valid_in, input ready_out);
  modport slave  (input lane_in, input valid_in, output ready_out);
endinterface

// File: rtl/lane_serializer.sv
// Per-lane parallel-to-serial stage: 2-entry word buffer, idle/COM fill,
// post-reset training preamble, LSB-first serial output at 32x word rate.
module lane_serializer #(
  parameter int unsigned INIT_IDLE_WORDS  = 4,
  parameter logic [31:0] IDLE_WORD        = 32'hBCBCBCBC,
  parameter logic [15:0] SENT_RESET_VALUE = 16'h0000
) (
  input  logic              clk_32f,
  input  logic              reset,
  lane_serializer_if.slave  up,
  output logic              serial_out,
  output logic              word_start,
  output logic              data_active,
  output logic              link_up,
  output logic [15:0]       words_sent
);

  localparam logic [15:0] IDLE_TARGET = 16'(INIT_IDLE_WORDS);

  typedef enum logic [0:0] {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        go_active_s;
  logic [15:0] idle_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [31:0] shift_r;
  logic [31:0] head_r;
  logic [31:0] tail_r;
  logic [1:0]  count_r;
  logic        boundary_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] load_word_s;

  assign boundary_s   = (bit_cnt_r == 5'd0);
  assign up.ready_out = (state_r == ST_ACTIVE) && (count_r < 2'd2);

  // Next-state logic: INIT leaves on the boundary that would start the extra idle word.
  always_comb begin
    state_next_s = state_r;
    go_active_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (boundary_s && (idle_cnt_r == IDLE_TARGET)) begin
          state_next_s = ST_ACTIVE;
          go_active_s  = 1'b1;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_ACTIVE: state_next_s = ST_ACTIVE;
      default:   state_next_s = ST_INIT;
    endcase
  end

  // Slot load decision uses the buffer contents as they were before the edge.
  always_comb begin
    push_s      = up.valid_in && up.ready_out;
    pop_s       = boundary_s && (state_r == ST_ACTIVE) && (count_r != 2'd0);
    load_word_s = IDLE_WORD;
    if (pop_s) begin
      load_word_s = head_r;
    end else begin
      load_word_s = IDLE_WORD;
    end
  end

  // State register, preamble idle-word counter and link status.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_INIT;
      idle_cnt_r <= 16'd0;
      link_up    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (boundary_s && (state_r == ST_INIT) && !go_active_s) begin
        idle_cnt_r <= idle_cnt_r + 16'd1;
      end
      if (go_active_s) begin
        link_up <= 1'b1;
      end
    end
  end

  // Two-entry buffer; push and pop together only happen at count 1.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      head_r  <= 32'd0;
      tail_r  <= 32'd0;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= up.lane_in;
          end else begin
            tail_r <= up.lane_in;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          head_r <= up.lane_in;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Shifter: load a full word on a boundary, otherwise shift one bit out per edge.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_r   <= 5'd0;
      shift_r     <= 32'd0;
      serial_out  <= 1'b0;
      word_start  <= 1'b0;
      data_active <= 1'b0;
      words_sent  <= SENT_RESET_VALUE;
    end else begin
      bit_cnt_r  <= bit_cnt_r + 5'd1;
      word_start <= boundary_s;
      if (boundary_s) begin
        serial_out  <= load_word_s[0];
        shift_r     <= {1'b0, load_word_s[31:1]};
        data_active <= pop_s;
        if (pop_s && (words_sent != 16'hFFFF)) begin
          words_sent <= words_sent + 16'd1;
        end
      end else begin
        serial_out <= shift_r[0];
        shift_r    <= {1'b0, shift_r[31:1]};
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench: edge-numbered slot model with a word queue drives
// randomized stimulus into one default lane and one saturation-preset lane.
module tb_lane_serializer;

  localparam logic [31:0] IDLE = 32'hBCBCBCBC;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_32f = ~clk_32f;

  lane_serializer_if tb_if();
  lane_serializer_if sat_if();

  logic        serial_out, word_start, data_active, link_up;
  logic [15:0] words_sent;
  logic        s2_serial, s2_ws, s2_da, s2_link;
  logic [15:0] s2_sent;

  assign sat_if.valid_in = 1'b1;
  assign sat_if.lane_in  = 32'h5A5A_C3C3;

  lane_serializer dut (
    .clk_32f(clk_32f), .reset(reset), .up(tb_if),
    .serial_out(serial_out), .word_start(word_start), .data_active(data_active),
    .link_up(link_up), .words_sent(words_sent)
  );

  lane_serializer #(.SENT_RESET_VALUE(16'hFFFD)) dut_sat (
    .clk_32f(clk_32f), .reset(reset), .up(sat_if),
    .serial_out(s2_serial), .word_start(s2_ws), .data_active(s2_da),
    .link_up(s2_link), .words_sent(s2_sent)
  );

  int asserts  = 0;
  int failures = 0;

  // Reference model: edge number since reset release, pending word queue.
  int          n;
  logic [31:0] q[$];
  logic [31:0] cur;
  logic        cur_data, m_link, m_ready, m_acc, exp_bit, exp_ws;
  logic [15:0] m_sent, m_sent2;

  task automatic tick(input logic v, input logic [31:0] d);
    int idx;
    tb_if.valid_in = v;
    tb_if.lane_in  = d;
    m_acc = v && m_ready;
    @(posedge clk_32f); #1;
    n++;
    idx = (n - 1) % 32;
    if (idx == 0) begin
      if (n > 129 && q.size() > 0) begin
        cur = q.pop_front();
        cur_data = 1'b1;
        if (m_sent != 16'hFFFF) m_sent++;
      end else begin
        cur = IDLE;
        cur_data = 1'b0;
      end
      if (n > 129 && m_sent2 != 16'hFFFF) m_sent2++;
      if (n == 129) m_link = 1'b1;
    end
    if (m_acc) q.push_back(d);
    m_ready = m_link && (q.size() < 2);
    exp_bit = cur[idx];
    exp_ws  = (idx == 0);
  endtask

  task automatic reset_and_preamble();
    tb_if.valid_in = 1'b1;
    tb_if.lane_in  = $urandom;
    reset = 1'b0;
    n = 0; q.delete(); m_link = 1'b0; m_ready = 1'b0; m_acc = 1'b0;
    m_sent = 16'h0000; m_sent2 = 16'hFFFD; cur = IDLE; cur_data = 1'b0;
    repeat (5) begin
      @(posedge clk_32f); #1;
      asserts++;
      if ({serial_out, word_start, data_active, link_up, tb_if.ready_out} !== 5'b00000 ||
          words_sent !== 16'h0000 || s2_sent !== 16'hFFFD) begin
        failures++;
        $display("FAIL reset_state: got outs=%b sent=%h sent2=%h required 00000 0000 fffd",
                 {serial_out, word_start, data_active, link_up, tb_if.ready_out}, words_sent, s2_sent);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 129; i++) begin
      tick(1'b1, $urandom);
      asserts++;
      if (serial_out !== exp_bit || word_start !== exp_ws || data_active !== cur_data ||
          link_up !== m_link || tb_if.ready_out !== m_ready || words_sent !== m_sent) begin
        failures++;
        $display("FAIL preamble edge %0d: got ser=%b ws=%b da=%b lu=%b rdy=%b sent=%0d required %b %b %b %b %b %0d",
                 n, serial_out, word_start, data_active, link_up, tb_if.ready_out, words_sent,
                 exp_bit, exp_ws, cur_data, m_link, m_ready, m_sent);
      end
    end
  endtask

  task automatic test_reset();
    reset_and_preamble();
    asserts++;
    if (link_up !== 1'b1 || tb_if.ready_out !== 1'b1) begin
      failures++;
      $display("FAIL link_after_129: got lu=%b rdy=%b required 1 1", link_up, tb_if.ready_out);
    end
  endtask

  task automatic test_single();
    logic [31:0] rx;
    rx = 32'd0;
    while (n < 224) begin
      tick((n + 1) == 130, 32'hA5A5_0F01);
      asserts++;
      if (serial_out !== exp_bit || word_start !== exp_ws || data_active !== cur_data ||
          link_up !== m_link || tb_if.ready_out !== m_ready || words_sent !== m_sent) begin
        failures++;
        $display("FAIL single edge %0d: got ser=%b ws=%b da=%b lu=%b rdy=%b sent=%0d required %b %b %b %b %b %0d",
                 n, serial_out, word_start, data_active, link_up, tb_if.ready_out, words_sent,
                 exp_bit, exp_ws, cur_data, m_link, m_ready, m_sent);
      end
      if (n >= 161 && n <= 192) rx[n - 161] = serial_out;
      if (n == 193) begin
        asserts++;
        if (data_active !== 1'b0 || word_start !== 1'b1 || words_sent !== 16'd1) begin
          failures++;
          $display("FAIL single_end: got da=%b ws=%b sent=%0d required 0 1 1", data_active, word_start, words_sent);
        end
      end
    end
    asserts++;
    if (rx !== 32'hA5A5_0F01) begin
      failures++;
      $display("FAIL single_word: got %h required a5a50f01", rx);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] w [4];
    logic [31:0] rx [4];
    int idx;
    reset_and_preamble();
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; rx[i] = 32'd0; end
    idx = 0;
    while (n < 288) begin
      tick(idx < 4, w[idx & 3]);
      if (m_acc) idx++;
      asserts++;
      if (serial_out !== exp_bit || word_start !== exp_ws || data_active !== cur_data ||
          link_up !== m_link || tb_if.ready_out !== m_ready || words_sent !== m_sent) begin
        failures++;
        $display("FAIL back_pressure edge %0d: got ser=%b ws=%b da=%b lu=%b rdy=%b sent=%0d required %b %b %b %b %b %0d",
                 n, serial_out, word_start, data_active, link_up, tb_if.ready_out, words_sent,
                 exp_bit, exp_ws, cur_data, m_link, m_ready, m_sent);
      end
      if (n == 131 || n == 161) begin
        asserts++;
        if (tb_if.ready_out !== (n == 161)) begin
          failures++;
          $display("FAIL bp_ready edge %0d: got %b required %b", n, tb_if.ready_out, (n == 161));
        end
      end
      if (n >= 161) begin
        rx[(n - 161) / 32][(n - 161) % 32] = serial_out;
        asserts++;
        if (data_active !== 1'b1) begin
          failures++;
          $display("FAIL bp_gap edge %0d: got da=%b required 1", n, data_active);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if (rx[i] !== w[i]) begin
        failures++;
        $display("FAIL bp_order word %0d: got %h required %h", i, rx[i], w[i]);
      end
    end
    asserts++;
    if (words_sent !== 16'd4) begin
      failures++;
      $display("FAIL bp_count: got %0d required 4", words_sent);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] a, b, rxa, rxb;
    int nx;
    a = $urandom; b = $urandom; rxa = 32'd0; rxb = 32'd0;
    while (n < 384) begin
      nx = n + 1;
      tick(nx == 290 || nx == 321, (nx == 321) ? b : a);
      asserts++;
      if (serial_out !== exp_bit || word_start !== exp_ws || data_active !== cur_data ||
          link_up !== m_link || tb_if.ready_out !== m_ready || words_sent !== m_sent) begin
        failures++;
        $display("FAIL push_pop edge %0d: got ser=%b ws=%b da=%b lu=%b rdy=%b sent=%0d required %b %b %b %b %b %0d",
                 n, serial_out, word_start, data_active, link_up, tb_if.ready_out, words_sent,
                 exp_bit, exp_ws, cur_data, m_link, m_ready, m_sent);
      end
      if (n == 321) begin
        asserts++;
        if (tb_if.ready_out !== 1'b1 || data_active !== 1'b1) begin
          failures++;
          $display("FAIL push_pop_count: got rdy=%b da=%b required 1 1", tb_if.ready_out, data_active);
        end
      end
      if (n >= 321 && n <= 352) rxa[n - 321] = serial_out;
      if (n >= 353) rxb[n - 353] = serial_out;
    end
    asserts++;
    if (rxa !== a || rxb !== b) begin
      failures++;
      $display("FAIL push_pop_order: got %h %h required %h %h", rxa, rxb, a, b);
    end
  endtask

  task automatic test_random();
    while (n < 1024) begin
      tick($urandom_range(0, 3) == 0, $urandom);
      asserts++;
      if (serial_out !== exp_bit || word_start !== exp_ws || data_active !== cur_data ||
          link_up !== m_link || tb_if.ready_out !== m_ready || words_sent !== m_sent) begin
        failures++;
        $display("FAIL random edge %0d: got ser=%b ws=%b da=%b lu=%b rdy=%b sent=%0d required %b %b %b %b %b %0d",
                 n, serial_out, word_start, data_active, link_up, tb_if.ready_out, words_sent,
                 exp_bit, exp_ws, cur_data, m_link, m_ready, m_sent);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nx;
    reset_and_preamble();
    while (n < 178) begin
      nx = n + 1;
      tick(nx == 130 || nx == 162 || nx == 163, $urandom);
      asserts++;
      if (serial_out !== exp_bit || word_start !== exp_ws || data_active !== cur_data ||
          link_up !== m_link || tb_if.ready_out !== m_ready || words_sent !== m_sent) begin
        failures++;
        $display("FAIL reset_mid_setup edge %0d: got ser=%b ws=%b da=%b lu=%b rdy=%b sent=%0d required %b %b %b %b %b %0d",
                 n, serial_out, word_start, data_active, link_up, tb_if.ready_out, words_sent,
                 exp_bit, exp_ws, cur_data, m_link, m_ready, m_sent);
      end
    end
    reset = 1'b0;
    #1;
    asserts++;
    if ({serial_out, word_start, data_active, link_up, tb_if.ready_out} !== 5'b00000 || words_sent !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async: got outs=%b sent=%h required 00000 0000",
               {serial_out, word_start, data_active, link_up, tb_if.ready_out}, words_sent);
    end
    reset_and_preamble();
    while (n < 260) begin
      tick(1'b0, 32'd0);
      asserts++;
      if (serial_out !== exp_bit || data_active !== 1'b0 || words_sent !== 16'd0) begin
        failures++;
        $display("FAIL reset_stale edge %0d: got ser=%b da=%b sent=%0d required %b 0 0",
                 n, serial_out, data_active, words_sent, exp_bit);
      end
    end
  endtask

  task automatic test_saturation();
    reset_and_preamble();
    while (n < 260) begin
      tick(1'b0, 32'd0);
      asserts++;
      if (s2_sent !== m_sent2) begin
        failures++;
        $display("FAIL saturation edge %0d: got %h required %h", n, s2_sent, m_sent2);
      end
    end
    asserts++;
    if (s2_sent !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturation_final: got %h required ffff", s2_sent);
    end
  endtask

  initial begin
    reset = 1'b0;
    tb_if.valid_in = 1'b0;
    tb_if.lane_in  = 32'd0;
    test_reset();
    test_single();
    test_back_pressure();
    test_push_pop();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Per-lane parallel-to-serial stage directly downstream of the byte-striping block: consumes one 32-bit lane word plus valid and emits it LSB-first as a serial bit stream at 32× the lane word rate. It absorbs the striper's bursty valid with a 2-entry buffer and ready back-pressure. It fills empty word slots with an idle/COM pattern and sends a fixed training preamble after reset. One instance per lane (lane0, lane1).

## Interface
Parameters:
- INIT_IDLE_WORDS, 4, number of idle words sent after reset before data is accepted (≥1)
- IDLE_WORD, 32'hBCBCBCBC, pattern sent in any slot without data (four COM symbols)

Ports:
- clk_32f  input  1  bit-rate clock; the only clock
- reset  input  1  asynchronous, active-low reset
- lane_in  input  32  lane word from the striper
- valid_in  input  1  lane_in holds a word to transfer
- ready_out  output  1  block can accept a word this cycle
- serial_out  output  1  serial bit, LSB first
- word_start  output  1  high while serial_out carries bit 0 of any word (data or idle)
- data_active  output  1  high while serial_out carries a bit of a data word
- link_up  output  1  training preamble complete
- words_sent  output  16  count of data words started, saturating

## Operation
- Reset (reset=0, asynchronous): serial_out=0, word_start=0, data_active=0, link_up=0, ready_out=0, words_sent=0, buffer emptied, bit counter=0, state=INIT.
  - Reset asserted mid-word aborts the word.
  - Buffered words are discarded.
- Transfer: a word moves on a rising edge with valid_in=1 and ready_out=1.
  - valid_in while ready_out=0 is ignored; upstream holds its word.
- ready_out = (state==ACTIVE) && (buffer count < 2). Combinational from registered state.
- Buffer: 2-entry FIFO.
  - Simultaneous push and pop on one edge is legal at count 1 and leaves the count unchanged.
  - No push is possible at count 2.
- Slot boundary: the first rising edge after reset release, then every 32nd edge. On each boundary the shift register loads:
  - the FIFO head (popped) if state==ACTIVE and the pre-edge FIFO count > 0;
  - otherwise IDLE_WORD.
- The load decision uses pre-edge FIFO contents. A word loads at the first boundary strictly after its acceptance edge.
- Between boundaries the block shifts right one bit per edge. serial_out is the registered current bit.
- State machine:
  - INIT: sends only idle words. Counts idle words started. At the boundary that would start word INIT_IDLE_WORDS+1, it moves to ACTIVE, sets link_up=1, and loads idle on that boundary.
  - ACTIVE: stays until reset. No other transitions.
- data_active is registered and set at each boundary: 1 when a FIFO word loads, 0 when idle loads. It holds for all 32 bits.
- words_sent increments by 1 at each boundary that loads a data word and saturates at 16'hFFFF.
- Bit counter is 5-bit and wraps 31→0 at each boundary.

## Timing
- Edges are numbered from 1 = first rising edge with reset=1. The bit on serial_out after edge n has index (n−1) mod 32; boundaries occur at n ≡ 1 (mod 32).
- Edge 1: serial_out=IDLE_WORD[0], word_start=1. Every edge outputs one bit with no gaps.
- Preamble (INIT_IDLE_WORDS=4): idle words occupy edges 1–128.
  - After edge 129, link_up=1 and ready_out=1 (buffer empty); idle word 5 begins.
  - The earliest data acceptance is edge 130. Its first bit appears after edge 161.
- Latency: acceptance at edge k → bit 0 appears after the first boundary edge > k, i.e. 1–32 edges.
- A continuous stream (one word per 32 cycles) produces back-to-back data words with no idle gaps.
- Back-pressure: two words are buffered while a third is in flight. ready_out drops after the second push and re-rises after the next boundary pop.

## Test plan
- Reset/preamble: reset low 5 cycles, then high; valid_in=1 throughout.
  - Required: 128 bits of 0xBCBCBCBC pattern (LSB first); link_up and ready_out low until after edge 129.
- Single word: accept 32'hA5A5_0F01 at edge 130.
  - Required: serial_out after edges 161–192 equals 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,…; data_active=1 exactly for edges 161–192; words_sent=1; idle resumes at edge 193.
- Back-pressure: present 4 words (1,2,3,4) with valid_in held from edge 130.
  - Required: words 1 and 2 accepted immediately; ready_out=0 until after edge 161.
  - Required: the words serialize in order 1,2,3,4 with no idle slot between them; words_sent=4.
- Simultaneous push/pop: FIFO count 1; push exactly on a boundary edge.
  - Required: count stays 1, the popped word is the older one, and the pushed word starts at the next boundary.
- Reset mid-operation: assert reset during bit 17 of a data word with 2 words buffered.
  - Required: all outputs go to 0 immediately; after release the preamble restarts and no buffered word is ever emitted.
- Saturation: force 65 537 data words (or preload via parameterized shortened run).
  - Required: words_sent sticks at 16'hFFFF.
